tt_um_opencores_count_checker: RTL and testbench

Receive-side companion to the 2-bit counter tile. It samples a 2-bit free-running count on ui_in[1:0], which another tile or an external source drives. It synchronises the samples, checks that every change is a +1 (mod 4) step, acquires and holds lock, and reports lock, error pulses and a saturating error count on the Tiny Tapeout pins.

---
 rtl/count_check_pkg.sv | 8 +
 rtl/count_sync.sv | 16 +
 rtl/tt_um_opencores_count_checker.sv | 96 +++++++++
 tb/tb_tt_um_opencores_count_checker.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/count_check_pkg.sv
// count_check_pkg: shared state codes, count width and the +1 mod 4 helper for the count checker.
package count_check_pkg;
  localparam int COUNT_W = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;
  function automatic logic [COUNT_W-1:0] next_count(input logic [COUNT_W-1:0] c);
    return COUNT_W'(c + 1'b1);
  endfunction
endpackage

// File: rtl/count_sync.sv
// count_sync: SYNC_STAGES-deep multi-bit synchroniser, async active-low reset.
module count_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [SYNC_STAGES-1:0][W-1:0] r_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/tt_um_opencores_count_checker.sv
// tt_um_opencores_count_checker: checks a 2-bit count advances by +1 mod 4, tracks lock and errors.
// Optional stall timeout enabled by defining COUNT_CHECK_STALL_EN.
module tt_um_opencores_count_checker
  import count_check_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W = 6,
  parameter int TIMEOUT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  logic [2:0] w_s;
  logic [COUNT_W-1:0] w_cnt, r_prev, r_exp;
  logic [3:0] r_good_run;
  logic [ERR_W-1:0] r_err_count;
  logic r_err_pulse, w_clr, w_change, w_err, w_timeout, w_stall;
  state_t r_state;
  count_sync #(.SYNC_STAGES(SYNC_STAGES), .W(3)) u_sync (
    .clk(clk), .rst_n(rst_n), .i_d(ui_in[2:0]), .o_q(w_s)
  );
  assign w_cnt = w_s[1:0];
  assign w_clr = w_s[2];
  assign w_change = w_cnt != r_prev;
  assign w_err = w_change && (w_cnt != next_count(r_prev));
`ifdef COUNT_CHECK_STALL_EN
  logic [TIMEOUT_W-1:0] r_timer;
  logic r_stall;
  // Timer saturates so a long hold outside LOCKED cannot wrap into a false timeout later.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_timer <= '0;
      r_stall <= 1'b0;
    end else begin
      r_timer <= (r_state == IDLE || w_change) ? '0 : (&r_timer ? r_timer : r_timer + 1'b1);
      r_stall <= w_timeout ? 1'b1 : (w_change ? 1'b0 : r_stall);
    end
  assign w_timeout = (r_state == LOCKED) && !w_change && (&r_timer);
  assign w_stall = r_stall;
  logic w_unused;
  assign w_unused = &{ena, uio_in, ui_in[7:3], 1'b0};
`else
  assign w_timeout = 1'b0;
  assign w_stall = 1'b0;
  logic w_unused;
  assign w_unused = &{ena, uio_in, ui_in[7:3], (TIMEOUT_W > 0)};
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_prev <= '0;
      r_exp <= '0;
      r_good_run <= '0;
      r_err_count <= '0;
      r_err_pulse <= 1'b0;
    end else begin
      r_prev <= w_cnt;
      r_exp <= next_count(w_cnt);
      r_err_pulse <= 1'b0;
      // Clear beats a coincident error for the count only; pulse and FSM still react.
      if (w_clr) r_err_count <= '0;
      else if (r_state == LOCKED && (w_err || w_timeout) && !(&r_err_count))
        r_err_count <= r_err_count + 1'b1;
      case (r_state)
        IDLE: begin
          r_state <= ACQUIRE;
          r_good_run <= '0;
        end
        ACQUIRE:
          if (w_err) r_good_run <= '0;
          else if (w_change) begin
            if (r_good_run == 4'(LOCK_COUNT - 1)) begin
              r_state <= LOCKED;
              r_good_run <= '0;
            end else r_good_run <= r_good_run + 1'b1;
          end
        LOCKED:
          if (w_err || w_timeout) begin
            r_err_pulse <= 1'b1;
            r_state <= ACQUIRE;
            r_good_run <= '0;
          end
        default: r_state <= IDLE;
      endcase
    end
  assign uo_out = {r_err_count, r_err_pulse, r_state == LOCKED};
  assign uio_out = {1'b0, w_stall, r_state, r_exp, r_prev};
  assign uio_oe = 8'hFF;
endmodule

// File: tb/tb_tt_um_opencores_count_checker.sv
// tb_tt_um_opencores_count_checker: directed self-checking bench for the count checker.
module tb_tt_um_opencores_count_checker;
`ifdef COUNT_CHECK_STALL_EN
  localparam int TW = 4;
`else
  localparam int TW = 8;
`endif
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in = '0, uio_in = '0, uo_out, uio_out, uio_oe;
  int n_cmp = 0, n_fail = 0, exp_cnt = 0;
  logic [1:0] cur = '0;
  tt_um_opencores_count_checker #(.SYNC_STAGES(2), .LOCK_COUNT(4), .ERR_W(6), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] v, input logic clr);
    ui_in = {5'b0, clr, v};
  endtask
  // Four +1 changes from the current value; locked is visible 3 edges after the last drive.
  task automatic relock();
    for (int k = 0; k < 4; k++) begin
      cur = cur + 2'd1;
      drive(cur, 1'b0);
      step(1);
    end
    step(2);
  endtask
  initial begin
    ui_in = 8'($urandom);
    uio_in = 8'($urandom);
    step(3);
    chk("rst_uo", uo_out, 8'h00);
    chk("rst_uio", uio_out, 8'h00);
    chk("rst_oe", uio_oe, 8'hFF);
    ui_in = '0;
    rst_n = 1'b1;
    chk("rel_idle", uio_out[5:4], 2'd0);
    step(1);
    chk("rel_acq", uio_out[5:4], 2'd1);
    step(2);
    drive(2'd1, 1'b0); step(1);
    drive(2'd2, 1'b0); step(1);
    drive(2'd3, 1'b0); step(1);
    drive(2'd0, 1'b0); step(1);
    drive(2'd1, 1'b0); step(1);
    cur = 2'd1;
    chk("lock_early", uo_out[0], 1'b0);
    step(1);
    chk("lock", uo_out[0], 1'b1);
    chk("lock_state", uio_out[5:4], 2'd2);
    chk("lock_cnt", uo_out[7:2], 6'd0);
    chk("lock_pulse", uo_out[1], 1'b0);
    cur = 2'd3;
    drive(cur, 1'b0);
    step(2);
    chk("err_pre_pulse", uo_out[1], 1'b0);
    chk("err_pre_lock", uo_out[0], 1'b1);
    step(1);
    chk("err_pulse", uo_out[1], 1'b1);
    chk("err_cnt", uo_out[7:2], 6'd1);
    chk("err_unlock", uo_out[0], 1'b0);
    chk("err_state", uio_out[5:4], 2'd1);
    step(1);
    chk("err_pulse_end", uo_out[1], 1'b0);
    exp_cnt = 1;
    for (int i = 0; i < 70; i++) begin
      relock();
      chk("sat_lock", uo_out[0], 1'b1);
      cur = cur + 2'd2;
      drive(cur, 1'b0);
      step(3);
      exp_cnt = (exp_cnt < 63) ? exp_cnt + 1 : 63;
      chk("sat_pulse", uo_out[1], 1'b1);
      chk("sat_cnt", uo_out[7:2], 32'(exp_cnt));
    end
    chk("sat_final", uo_out[7:2], 6'd63);
    relock();
    chk("pre_clr_lock", uo_out[0], 1'b1);
    drive(cur, 1'b1);
    step(3);
    chk("clr_cnt", uo_out[7:2], 6'd0);
    chk("clr_lock", uo_out[0], 1'b1);
    drive(cur, 1'b0);
    step(3);
    cur = cur + 2'd2;
    drive(cur, 1'b1);
    step(3);
    chk("coin_pulse", uo_out[1], 1'b1);
    chk("coin_cnt", uo_out[7:2], 6'd0);
    chk("coin_unlock", uo_out[0], 1'b0);
    drive(cur, 1'b0);
    step(3);
    relock();
`ifdef COUNT_CHECK_STALL_EN
    step(15);
    chk("stall_pre_lock", uo_out[0], 1'b1);
    chk("stall_pre", uio_out[6], 1'b0);
    step(1);
    chk("stall_set", uio_out[6], 1'b1);
    chk("stall_unlock", uo_out[0], 1'b0);
    chk("stall_cnt", uo_out[7:2], 6'd1);
    chk("stall_pulse", uo_out[1], 1'b1);
    cur = cur + 2'd1;
    drive(cur, 1'b0);
    step(3);
    chk("stall_clear", uio_out[6], 1'b0);
`else
    step(100);
    chk("hold_lock", uo_out[0], 1'b1);
    chk("hold_stall", uio_out[6], 1'b0);
    chk("hold_pulse", uo_out[1], 1'b0);
    chk("hold_last", uio_out[1:0], cur);
    chk("hold_next", uio_out[3:2], 2'(cur + 2'd1));
`endif
    rst_n = 1'b0;
    #1;
    chk("mid_rst_uo", uo_out, 8'h00);
    chk("mid_rst_uio", uio_out, 8'h00);
    chk("mid_rst_oe", uio_oe, 8'hFF);
    step(1);
    rst_n = 1'b1;
    step(3);
    chk("post_rst_state", uio_out[5:4], 2'd1);
    chk("post_rst_lock", uo_out[0], 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
